// File: rtl/bu_pkg.sv
// Shared butterfly-unit definitions: pipeline depth and the lane unpack helper.
package bu_pkg;
  localparam int STAGES    = 2;
  localparam int LATENCY   = 2;
  localparam int MAX_LOGQ  = 64;
  localparam int MAX_LANES = 16;
  localparam int MAX_VEC   = MAX_LOGQ * MAX_LANES;

  // Caller zero-extends vec to MAX_VEC and truncates the result to its own LOGQ.
  function automatic logic [MAX_LOGQ-1:0] lane(input logic [MAX_VEC-1:0] vec,
                                                input int unsigned i,
                                                input int unsigned logq);
    return MAX_LOGQ'(vec >> (i * logq));
  endfunction
endpackage

// File: rtl/modaddsub_lane.sv
// One lane of the modular add/sub: stage-1 raw sum/difference, stage-2 correction by q.
module modaddsub_lane
  import bu_pkg::*;
#(
  parameter int LOGQ = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en1,
  input  logic            en2,
  input  logic            sub_in,
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  input  logic            sub_s1,
  input  logic [LOGQ-1:0] q_s1,
  output logic [LOGQ-1:0] c
);
  logic [LOGQ:0]   r_d, r_q, t;
  logic [LOGQ-1:0] c_d, c_q;

  always_comb begin
    r_d = sub_in ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    t   = r_q - {1'b0, q_s1};
    // Bit LOGQ is the borrow of the subtract (sub) or of the trial subtract of q (add).
    if (sub_s1) c_d = r_q[LOGQ] ? (r_q[LOGQ-1:0] + q_s1) : r_q[LOGQ-1:0];
    else        c_d = t[LOGQ]   ? r_q[LOGQ-1:0]          : t[LOGQ-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      if (en1) r_q <= r_d;
      if (en2) c_q <= c_d;
    end
  end

  assign c = c_q;
endmodule

// File: rtl/modaddsub_pipe.sv
// Two-stage multi-lane modular adder/subtractor with valid/ready flow control.
module modaddsub_pipe
  import bu_pkg::*;
#(
  parameter int LOGQ  = 64,
  parameter int LANES = 4,
  parameter int TAGW  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sub,
  input  logic [LOGQ-1:0]       in_q,
  input  logic [LANES*LOGQ-1:0] in_a,
  input  logic [LANES*LOGQ-1:0] in_b,
  input  logic [TAGW-1:0]       in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*LOGQ-1:0] out_c,
  output logic [TAGW-1:0]       out_tag
);
  logic            v1_d, v1_q, v2_d, v2_q;
  logic            adv1, adv2, en1, en2;
  logic            sub1_d, sub1_q;
  logic [LOGQ-1:0] q1_d, q1_q;
  logic [TAGW-1:0] tag1_d, tag1_q, tag2_d, tag2_q;
  logic [MAX_VEC-1:0] a_ext, b_ext;

  always_comb begin
    adv2   = !v2_q | out_ready;
    adv1   = !v1_q | adv2;
    en1    = adv1 & in_valid;
    en2    = adv2 & v1_q;
    v1_d   = adv1 ? in_valid : v1_q;
    v2_d   = adv2 ? v1_q : v2_q;
    sub1_d = en1 ? in_sub : sub1_q;
    q1_d   = en1 ? in_q   : q1_q;
    tag1_d = en1 ? in_tag : tag1_q;
    tag2_d = en2 ? tag1_q : tag2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      sub1_q <= 1'b0;
      q1_q   <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      sub1_q <= sub1_d;
      q1_q   <= q1_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
    end
  end

  assign a_ext = MAX_VEC'(in_a);
  assign b_ext = MAX_VEC'(in_b);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    modaddsub_lane #(.LOGQ(LOGQ)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .en1    (en1),
      .en2    (en2),
      .sub_in (in_sub),
      .a      (LOGQ'(lane(a_ext, i, LOGQ))),
      .b      (LOGQ'(lane(b_ext, i, LOGQ))),
      .sub_s1 (sub1_q),
      .q_s1   (q1_q),
      .c      (out_c[i*LOGQ +: LOGQ])
    );
  end

  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign out_tag   = tag2_q;
endmodule

// File: tb/tb_modaddsub_pipe.sv
// Directed bench for modaddsub_pipe at LOGQ=16, LANES=4, q=12289.
module tb_modaddsub_pipe;
  localparam int LOGQ = 16, LANES = 4, TAGW = 8;
  localparam logic [15:0] Q = 16'd12289;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, in_sub = 1'b0;
  logic [LOGQ-1:0] in_q = '0;
  logic [LANES*LOGQ-1:0] in_a = '0, in_b = '0, out_c;
  logic [TAGW-1:0] in_tag = '0, out_tag;
  logic out_valid, out_ready = 1'b1;
  int checks = 0, errors = 0;

  modaddsub_pipe #(.LOGQ(LOGQ), .LANES(LANES), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sub(in_sub), .in_q(in_q), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Present one transaction at #1 after an edge; returns #1 after the accepting edge.
  task automatic push(input logic sub, input logic [15:0] q, input logic [63:0] a,
                      input logic [63:0] b, input logic [7:0] tag);
    in_valid = 1'b1; in_sub = sub; in_q = q; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    reset = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (out_c !== 64'd0) begin errors++; $display("FAIL reset_out_c got %h want 0", out_c); end
    checks++; if (out_tag !== 8'd0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
  endtask

  task automatic test_add_nowrap();
    logic [63:0] exp_c;
    exp_c = {16'd12288, 16'd11000, 16'd3, 16'd300};
    @(posedge clk); #1;
    push(1'b0, Q, {16'd12288, 16'd5000, 16'd1, 16'd100}, {16'd0, 16'd6000, 16'd2, 16'd200}, 8'hA5);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_nowrap_early got valid %0b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_nowrap_latency got valid %0b want 1", out_valid); end
    checks++; if (out_c !== exp_c) begin errors++; $display("FAIL add_nowrap_c got %h want %h", out_c, exp_c); end
    checks++; if (out_tag !== 8'hA5) begin errors++; $display("FAIL add_nowrap_tag got %h want a5", out_tag); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_nowrap_single got valid %0b want 0", out_valid); end
  endtask

  task automatic test_add_wrap();
    logic [63:0] exp_c;
    exp_c = {16'd12287, 16'd0, 16'd711, 16'd0};
    push(1'b0, Q, {16'd12288, 16'd0, 16'd12000, 16'd12288}, {16'd12288, 16'd0, 16'd1000, 16'd1}, 8'h11);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_c !== exp_c) begin
      errors++; $display("FAIL add_wrap got v=%0b c=%h want v=1 c=%h", out_valid, out_c, exp_c); end
  endtask

  task automatic test_sub();
    logic [63:0] exp_c;
    exp_c = {16'd1, 16'd0, 16'd5, 16'd12284};
    push(1'b1, Q, {16'd0, 16'd7, 16'd10, 16'd5}, {16'd12288, 16'd7, 16'd5, 16'd10}, 8'h22);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_c !== exp_c) begin
      errors++; $display("FAIL sub got v=%0b c=%h want v=1 c=%h", out_valid, out_c, exp_c); end
    checks++; if (out_tag !== 8'h22) begin errors++; $display("FAIL sub_tag got %h want 22", out_tag); end
  endtask

  task automatic test_out_of_range();
    logic [63:0] exp_add, exp_sub;
    exp_add = {16'd53246, 16'd7711, 16'd0, 16'd65534};
    exp_sub = {16'd12288, 16'd57826, 16'd19999, 16'd12290};
    push(1'b0, Q, {16'd65535, 16'd20000, 16'd12289, 16'd65535}, {16'd0, 16'd0, 16'd0, 16'd65535}, 8'h33);
    @(posedge clk); #1;
    checks++; if (out_c !== exp_add) begin errors++; $display("FAIL oor_add got %h want %h", out_c, exp_add); end
    push(1'b1, Q, {16'd0, 16'd1, 16'd20000, 16'd0}, {16'd1, 16'd20000, 16'd1, 16'd65535}, 8'h34);
    @(posedge clk); #1;
    checks++; if (out_c !== exp_sub) begin errors++; $display("FAIL oor_sub got %h want %h", out_c, exp_sub); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e0, e1, e2;
    e0 = {16'd12288, 16'd11000, 16'd711, 16'd300};
    e1 = {16'd255, 16'd0, 16'd43, 16'd0};
    e2 = {16'd300, 16'd257, 16'd2, 16'd0};
    out_ready = 1'b1;
    in_valid = 1'b1; in_sub = 1'b0; in_q = Q; in_tag = 8'h40;
    in_a = {16'd12288, 16'd5000, 16'd12000, 16'd100}; in_b = {16'd0, 16'd6000, 16'd1000, 16'd200};
    @(posedge clk); #1;
    in_q = 16'd257; in_tag = 8'h41;
    in_a = {16'd256, 16'd0, 16'd200, 16'd256}; in_b = {16'd256, 16'd0, 16'd100, 16'd1};
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_c !== e0 || out_tag !== 8'h40) begin
      errors++; $display("FAIL b2b_0 got v=%0b c=%h t=%h want v=1 c=%h t=40", out_valid, out_c, out_tag, e0); end
    in_q = Q; in_tag = 8'h42;
    in_a = {16'd300, 16'd256, 16'd1, 16'd12288}; in_b = {16'd0, 16'd1, 16'd1, 16'd1};
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_c !== e1 || out_tag !== 8'h41) begin
      errors++; $display("FAIL b2b_1 got v=%0b c=%h t=%h want v=1 c=%h t=41", out_valid, out_c, out_tag, e1); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_c !== e2 || out_tag !== 8'h42) begin
      errors++; $display("FAIL b2b_2 got v=%0b c=%h t=%h want v=1 c=%h t=42", out_valid, out_c, out_tag, e2); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got valid %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int ns = 0, nr = 0, cyc = 0;
    logic seen_drop = 1'b0, prev_stall = 1'b0;
    logic [63:0] prev_c = '0, exp_c;
    logic [7:0] prev_tag = '0;
    in_sub = 1'b0; in_q = Q;
    while (nr < 8 && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc < 8);
      in_valid = (ns < 8);
      in_tag = 8'(ns);
      in_a = {16'(ns), 16'(ns), 16'(ns), 16'(ns * 10 + 1)};
      in_b = {16'd0, 16'd0, 16'd0, 16'(ns)};
      #1;
      if (out_ready) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready cyc %0d got %0b want 1", cyc, in_ready); end
      end
      if (in_ready === 1'b0) seen_drop = 1'b1;
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || out_c !== prev_c || out_tag !== prev_tag) begin
          errors++; $display("FAIL bp_stable cyc %0d got v=%0b c=%h t=%h want v=1 c=%h t=%h",
                             cyc, out_valid, out_c, out_tag, prev_c, prev_tag); end
      end
      if (out_valid && out_ready) begin
        exp_c = {16'(nr), 16'(nr), 16'(nr), 16'(nr * 11 + 1)};
        checks++; if (out_tag !== 8'(nr) || out_c !== exp_c) begin
          errors++; $display("FAIL bp_order got t=%h c=%h want t=%h c=%h", out_tag, out_c, 8'(nr), exp_c); end
        nr++;
      end
      prev_stall = out_valid && !out_ready;
      prev_c = out_c; prev_tag = out_tag;
      if (in_valid && in_ready) ns++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (nr != 8) begin errors++; $display("FAIL bp_count got %0d want 8", nr); end
    checks++; if (!seen_drop) begin errors++; $display("FAIL bp_drop got in_ready never 0 want 0 while full"); end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra got valid %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp_c;
    exp_c = {16'd12288, 16'd0, 16'd2, 16'd17};
    out_ready = 1'b1;
    push(1'b0, Q, {16'd1, 16'd1, 16'd1, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd1}, 8'h55);
    push(1'b0, Q, {16'd2, 16'd2, 16'd2, 16'd2}, {16'd2, 16'd2, 16'd2, 16'd2}, 8'h56);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got valid %0b want 1", out_valid); end
    reset = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", out_valid); end
    checks++; if (out_c !== 64'd0 || out_tag !== 8'd0) begin
      errors++; $display("FAIL rst_mid_data got c=%h t=%h want 0", out_c, out_tag); end
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %0b want 1", in_ready); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ghost cyc %0d got valid 1 want 0", k); end
    end
    push(1'b1, Q, {16'd0, 16'd9, 16'd5, 16'd20}, {16'd1, 16'd9, 16'd3, 16'd3}, 8'h77);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_early got valid %0b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_c !== exp_c || out_tag !== 8'h77) begin
      errors++; $display("FAIL rst_mid_next got v=%0b c=%h t=%h want v=1 c=%h t=77", out_valid, out_c, out_tag, exp_c); end
  endtask

  initial begin
    test_reset();
    test_add_nowrap();
    test_add_wrap();
    test_sub();
    test_out_of_range();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
